// File: rtl/mem_pkg.sv
// Shared definitions for the per-core load/store front end:
// RV32 size codes and the request state machine encoding.
package mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } lsu_state_t;

endpackage

// File: rtl/mem_align_check.sv
// Combinational legality and alignment check for one MEM-stage access.
// Both flags can be set together.
module mem_align_check
   import mem_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic [1:0] addr_lo,
   input  logic       load,
   input  logic       store,
   output logic       misaligned,
   output logic       illegal
);

   always_comb begin
      misaligned = 1'b0;
      illegal    = 1'b0;
      case (funct3)
         F3_B, F3_BU: begin
            misaligned = 1'b0;
         end
         F3_H, F3_HU: begin
            misaligned = addr_lo[0];
         end
         F3_W: begin
            misaligned = |addr_lo;
         end
         default: begin
            illegal = 1'b1;
         end
      endcase
      // Stores have no sign-extension variants.
      if (store && (funct3 == F3_BU || funct3 == F3_HU)) begin
         illegal = 1'b1;
      end
      if (load && store) begin
         illegal = 1'b1;
      end
   end

endmodule

// File: rtl/core_mem_port.sv
// Per-core load/store front end: holds one access until the arbiter grants it,
// returns registered data with a one-cycle response and counts stall cycles.
module core_mem_port
   import mem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic        req_load,
   input  logic        req_store,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_funct3,
   output logic        stall,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        misaligned,
   output logic        illegal,
   output logic        timeout_err,
   input  logic        perf_clear,
   output logic [31:0] stall_count,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [2:0]  bus_funct3,
   output logic        bus_read,
   output logic        bus_write,
   input  logic        bus_ready,
   input  logic [31:0] bus_rdata
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] WAIT_LIMIT = CW'(TIMEOUT_CYCLES);

   lsu_state_t    state;
   logic [CW-1:0] wait_cnt;
   logic          chk_misaligned;
   logic          chk_illegal;
   logic          issue;
   logic          hold_read;
   logic          hold_write;
   logic [31:0]   hold_addr;
   logic [31:0]   hold_wdata;
   logic [2:0]    hold_funct3;

   mem_align_check u_align (
      .funct3     (req_funct3),
      .addr_lo    (req_addr[1:0]),
      .load       (req_load),
      .store      (req_store),
      .misaligned (chk_misaligned),
      .illegal    (chk_illegal)
   );

   assign issue = (state == IDLE) && req_valid && !chk_misaligned && !chk_illegal;
   assign stall = req_valid && (state != DONE);

   // The request goes out in the issue cycle straight from the pipeline and is
   // replayed from the captured copy while waiting for the grant.
   always_comb begin
      bus_read   = 1'b0;
      bus_write  = 1'b0;
      bus_addr   = hold_addr;
      bus_wdata  = hold_wdata;
      bus_funct3 = hold_funct3;
      if (issue) begin
         bus_read   = req_load;
         bus_write  = req_store;
         bus_addr   = req_addr;
         bus_wdata  = req_wdata;
         bus_funct3 = req_funct3;
      end else if (state == WAIT) begin
         bus_read  = hold_read;
         bus_write = hold_write;
      end
      if (!rst_n) begin
         bus_read  = 1'b0;
         bus_write = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         resp_valid  <= 1'b0;
         resp_rdata  <= '0;
         misaligned  <= 1'b0;
         illegal     <= 1'b0;
         timeout_err <= 1'b0;
         hold_read   <= 1'b0;
         hold_write  <= 1'b0;
         hold_addr   <= '0;
         hold_wdata  <= '0;
         hold_funct3 <= '0;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  if (chk_misaligned || chk_illegal) begin
                     state       <= DONE;
                     resp_valid  <= 1'b1;
                     resp_rdata  <= '0;
                     misaligned  <= chk_misaligned;
                     illegal     <= chk_illegal;
                     timeout_err <= 1'b0;
                  end else begin
                     state       <= WAIT;
                     wait_cnt    <= '0;
                     hold_read   <= req_load;
                     hold_write  <= req_store;
                     hold_addr   <= req_addr;
                     hold_wdata  <= req_wdata;
                     hold_funct3 <= req_funct3;
                  end
               end
            end
            WAIT: begin
               // A grant on the final permitted cycle still completes normally.
               if (bus_ready) begin
                  state       <= DONE;
                  resp_valid  <= 1'b1;
                  resp_rdata  <= hold_read ? bus_rdata : 32'd0;
                  misaligned  <= 1'b0;
                  illegal     <= 1'b0;
                  timeout_err <= 1'b0;
                  wait_cnt    <= '0;
               end else if (wait_cnt == WAIT_LIMIT) begin
                  state       <= DONE;
                  resp_valid  <= 1'b1;
                  resp_rdata  <= '0;
                  misaligned  <= 1'b0;
                  illegal     <= 1'b0;
                  timeout_err <= 1'b1;
                  wait_cnt    <= '0;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_count <= '0;
      end else if (perf_clear) begin
         stall_count <= '0;
      end else if (stall && (stall_count != 32'hFFFF_FFFF)) begin
         stall_count <= stall_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_core_mem_port.sv
// Randomized bench for core_mem_port against a transaction-level model that
// predicts latency, flags, data and stall count from the access rules.
module tb_core_mem_port;

   localparam int T = 4;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_load;
   logic        req_store;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [2:0]  req_funct3;
   logic        stall;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        misaligned;
   logic        illegal;
   logic        timeout_err;
   logic        perf_clear;
   logic [31:0] stall_count;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [2:0]  bus_funct3;
   logic        bus_read;
   logic        bus_write;
   logic        bus_ready;
   logic [31:0] bus_rdata;

   int total = 0;
   int bad   = 0;

   logic [31:0] model_count = 32'd0;
   logic        exp_mis_q   = 1'b0;
   logic        exp_ill_q   = 1'b0;
   logic        exp_to_q    = 1'b0;
   logic [31:0] exp_rdata_q = 32'd0;

   core_mem_port #(.TIMEOUT_CYCLES(T)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_load    (req_load),
      .req_store   (req_store),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_funct3  (req_funct3),
      .stall       (stall),
      .resp_valid  (resp_valid),
      .resp_rdata  (resp_rdata),
      .misaligned  (misaligned),
      .illegal     (illegal),
      .timeout_err (timeout_err),
      .perf_clear  (perf_clear),
      .stall_count (stall_count),
      .bus_addr    (bus_addr),
      .bus_wdata   (bus_wdata),
      .bus_funct3  (bus_funct3),
      .bus_read    (bus_read),
      .bus_write   (bus_write),
      .bus_ready   (bus_ready),
      .bus_rdata   (bus_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, actual, expected, $time);
      end
   endtask

   task automatic stepModel(input logic exp_stall);
      if (perf_clear) model_count = 32'd0;
      else if (exp_stall && model_count != 32'hFFFF_FFFF) model_count = model_count + 32'd1;
   endtask

   task automatic idleCycle(input logic clr);
      req_valid  = 1'b0;
      req_load   = 1'($urandom_range(0, 1));
      req_store  = 1'($urandom_range(0, 1));
      req_addr   = $urandom;
      req_funct3 = 3'($urandom_range(0, 7));
      bus_ready  = 1'($urandom_range(0, 1));
      bus_rdata  = $urandom;
      perf_clear = clr;
      @(negedge clk);
      checkOutput("idle_resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("idle_stall", 32'(stall), 32'd0);
      checkOutput("idle_bus_read", 32'(bus_read), 32'd0);
      checkOutput("idle_bus_write", 32'(bus_write), 32'd0);
      checkOutput("idle_misaligned", 32'(misaligned), 32'(exp_mis_q));
      checkOutput("idle_illegal", 32'(illegal), 32'(exp_ill_q));
      checkOutput("idle_timeout", 32'(timeout_err), 32'(exp_to_q));
      checkOutput("idle_rdata", resp_rdata, exp_rdata_q);
      checkOutput("idle_stall_count", stall_count, model_count);
      stepModel(1'b0);
      @(posedge clk);
      #1;
   endtask

   // One access with req_valid held until its response; the arbiter grants
   // after 'delay' withheld WAIT cycles (never, if delay exceeds T).
   task automatic applyStimulus(input logic ld, input logic st, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int delay, input int clr_cyc);
      int          size;
      logic        mis;
      logic        ill;
      logic        fault;
      logic        to;
      int          lat;
      logic [31:0] exp_rd;
      case (f3)
         3'd0, 3'd4: size = 1;
         3'd1, 3'd5: size = 2;
         3'd2:       size = 4;
         default:    size = 0;
      endcase
      ill   = (ld && st) || (size == 0) || (st && f3[2]);
      mis   = (size == 2) ? addr[0] : ((size == 4) ? (addr[1:0] != 2'b00) : 1'b0);
      fault = mis || ill;
      to    = 1'b0;
      exp_rd = 32'd0;
      if (fault) begin
         lat = 1;
      end else if (delay <= T) begin
         lat    = delay + 2;
         exp_rd = ld ? rdata : 32'd0;
      end else begin
         lat = T + 2;
         to  = 1'b1;
      end
      for (int c = 0; c <= lat; c++) begin
         req_valid  = 1'b1;
         req_load   = ld;
         req_store  = st;
         req_funct3 = f3;
         req_addr   = addr;
         req_wdata  = wdata;
         perf_clear = (c == clr_cyc);
         if (fault || c == 0 || c == lat) bus_ready = 1'($urandom_range(0, 1));
         else bus_ready = (c == delay + 1);
         bus_rdata = (c == delay + 1) ? rdata : $urandom;
         @(negedge clk);
         checkOutput("stall_count", stall_count, model_count);
         if (c < lat) begin
            checkOutput("busy_resp_valid", 32'(resp_valid), 32'd0);
            checkOutput("busy_stall", 32'(stall), 32'd1);
            checkOutput("busy_bus_read", 32'(bus_read), 32'(!fault && ld));
            checkOutput("busy_bus_write", 32'(bus_write), 32'(!fault && st));
            if (!fault) begin
               checkOutput("bus_addr", bus_addr, addr);
               checkOutput("bus_wdata", bus_wdata, wdata);
               checkOutput("bus_funct3", 32'(bus_funct3), 32'(f3));
            end
         end else begin
            checkOutput("done_resp_valid", 32'(resp_valid), 32'd1);
            checkOutput("done_stall", 32'(stall), 32'd0);
            checkOutput("done_bus_read", 32'(bus_read), 32'd0);
            checkOutput("done_bus_write", 32'(bus_write), 32'd0);
            checkOutput("done_misaligned", 32'(misaligned), 32'(mis));
            checkOutput("done_illegal", 32'(illegal), 32'(ill));
            checkOutput("done_timeout", 32'(timeout_err), 32'(to));
            checkOutput("done_rdata", resp_rdata, exp_rd);
         end
         stepModel(c < lat);
         @(posedge clk);
         #1;
      end
      exp_mis_q   = mis;
      exp_ill_q   = ill;
      exp_to_q    = to;
      exp_rdata_q = exp_rd;
   endtask

   task automatic resetMidWait();
      req_valid  = 1'b1;
      req_load   = 1'b1;
      req_store  = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h0000_0200;
      req_wdata  = 32'd0;
      bus_ready  = 1'b0;
      perf_clear = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checkOutput("pre_reset_bus_read", 32'(bus_read), 32'd1);
         stepModel(1'b1);
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("reset_bus_read", 32'(bus_read), 32'd0);
      @(posedge clk);
      #1;
      rst_n       = 1'b1;
      model_count = 32'd0;
      exp_mis_q   = 1'b0;
      exp_ill_q   = 1'b0;
      exp_to_q    = 1'b0;
      exp_rdata_q = 32'd0;
      idleCycle(1'b0);
      idleCycle(1'b0);
   endtask

   initial begin
      logic        ld;
      logic        st;
      logic [31:0] addr;
      int          sel;
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_load   = 1'b0;
      req_store  = 1'b0;
      req_addr   = 32'd0;
      req_wdata  = 32'd0;
      req_funct3 = 3'd0;
      perf_clear = 1'b0;
      bus_ready  = 1'b0;
      bus_rdata  = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idleCycle(1'b0);

      applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 0, -1);
      applyStimulus(1'b0, 1'b1, 3'b010, 32'h0000_0104, 32'h1234_5678, 32'hCAFE_F00D, 3, -1);
      idleCycle(1'b0);
      applyStimulus(1'b1, 1'b0, 3'b001, 32'h0000_0101, 32'd0, 32'd0, 0, -1);
      applyStimulus(1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'd0, 32'd0, 0, -1);
      applyStimulus(1'b1, 1'b1, 3'b010, 32'h0000_0100, 32'd0, 32'd0, 0, -1);
      applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0108, 32'd0, 32'h5555_AAAA, T + 3, -1);
      idleCycle(1'b0);
      applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_010C, 32'd0, 32'h0BAD_F00D, T, -1);
      resetMidWait();
      applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'd0, 32'h1357_9BDF, 1, -1);
      applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'd0, 32'hA5A5_0001, 0, -1);
      applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'd0, 32'hA5A5_0002, 0, 1);

      for (int n = 0; n < 60; n++) begin
         sel = int'($urandom_range(0, 9));
         ld  = (sel < 5) || (sel == 9);
         st  = (sel >= 5);
         addr = $urandom;
         if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
         applyStimulus(ld, st, 3'($urandom_range(0, 7)), addr, $urandom, $urandom,
                       int'($urandom_range(0, T + 2)),
                       ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1);
         if ($urandom_range(0, 2) == 0) idleCycle(1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
